// File: rtl/uart_pkg.sv
// Shared constants for the UART FIFO slice.
//   UART_DATA_WIDTH / UART_ADDR_WIDTH : default word and address widths.
//   fifo_mode_e                       : read-mode encodings for the FWFT parameter.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned UART_ADDR_WIDTH = 4;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Handshake/status bundle between a UART FIFO and its user (shifter or SFR side).
//   master : the user; drives flush, write/read requests, thresholds, err_clr.
//   slave  : the FIFO; drives read data, valid, occupancy and status flags.
interface uart_fifo_ctrl_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = UART_ADDR_WIDTH
);

    logic                  flush;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   af_thresh;
    logic [ADDR_WIDTH:0]   ae_thresh;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output flush, w_en, w_data, r_en, af_thresh, ae_thresh, err_clr,
        input  r_data, r_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, w_en, w_data, r_en, af_thresh, ae_thresh, err_clr,
        output r_data, r_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// 1W1R register array for the UART FIFO.
//   clk   : write clock.
//   we    : write enable; waddr/wdata captured on the rising edge.
//   raddr : asynchronous read address; rdata follows it combinationally.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = UART_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Parametrised synchronous FIFO for the 8051 UART TX/RX paths.
//   clk, rst : single clock; synchronous active-high reset.
//   bus      : slave side of uart_fifo_ctrl_if (write/read handshake, flush,
//              thresholds, occupancy, almost/full/empty and sticky error flags).
// FWFT = MODE_STD gives a registered read with 1-cycle latency; MODE_FWFT shows the
// head entry combinationally with r_valid = !empty.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = UART_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2 ** ADDR_WIDTH,
    parameter int unsigned FWFT       = int'(MODE_STD)
) (
    input logic            clk,
    input logic            rst,
    uart_fifo_ctrl_if.slave bus
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;

    logic [PtrW-1:0]       w_ptr_q, w_ptr_d;
    logic [PtrW-1:0]       r_ptr_q, r_ptr_d;
    logic [PtrW-1:0]       count_q, count_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc, mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        wr_acc  = bus.w_en && !full_q;
        rd_acc  = bus.r_en && !empty_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (bus.flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
        end else begin
            if (wr_acc) w_ptr_d = w_ptr_q + PtrW'(1);
            if (rd_acc) r_ptr_d = r_ptr_q + PtrW'(1);
        end
        // Pointers carry one extra bit, so the difference is the true occupancy.
        count_d = w_ptr_d - r_ptr_d;
        // A new error wins over a simultaneous clear; flush suppresses error detection.
        ovf_d = (ovf_q && !bus.err_clr) || (bus.w_en && full_q && !bus.flush);
        unf_d = (unf_q && !bus.err_clr) || (bus.r_en && empty_q && !bus.flush);
    end

    assign mem_we = wr_acc && !bus.flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= (count_d == PtrW'(FIFO_DEPTH));
            empty_q <= (w_ptr_d == r_ptr_d);
            // Thresholds are live inputs, compared every cycle.
            af_q    <= (count_d >= bus.af_thresh);
            ae_q    <= (count_d <= bus.ae_thresh);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (bus.w_data),
        .raddr (r_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == int'(MODE_FWFT)) begin : g_fwft
        assign bus.r_data  = mem_rdata;
        assign bus.r_valid = !empty_q;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_data_q;
        logic                  r_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= rd_acc && !bus.flush;
                if (rd_acc && !bus.flush) begin
                    r_data_q <= mem_rdata;
                end
            end
        end

        assign bus.r_data  = r_data_q;
        assign bus.r_valid = r_valid_q;
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: one standard-mode and one FWFT instance.
module tb_uart_fifo_ctrl;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) s ();
    uart_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) f ();

    uart_fifo_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .FIFO_DEPTH (16),
        .FWFT       (0)
    ) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (s.slave)
    );

    uart_fifo_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .FIFO_DEPTH (16),
        .FWFT       (1)
    ) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"}, 32'(s.count), 0);
        chk({tag, " empty"}, 32'(s.empty), 1);
        chk({tag, " full"}, 32'(s.full), 0);
        chk({tag, " almost_empty"}, 32'(s.almost_empty), 1);
        chk({tag, " almost_full"}, 32'(s.almost_full), 0);
        chk({tag, " r_data"}, 32'(s.r_data), 0);
        chk({tag, " r_valid"}, 32'(s.r_valid), 0);
        chk({tag, " overflow"}, 32'(s.overflow), 0);
        chk({tag, " underflow"}, 32'(s.underflow), 0);
    endtask

    initial begin
        rst = 1'b1;
        s.flush = 0; s.w_en = 0; s.w_data = '0; s.r_en = 0; s.err_clr = 0;
        s.af_thresh = 5'd14; s.ae_thresh = 5'd2;
        f.flush = 0; f.w_en = 0; f.w_data = '0; f.r_en = 0; f.err_clr = 0;
        f.af_thresh = 5'd14; f.ae_thresh = 5'd2;
        cyc();
        cyc();
        rst = 1'b0;
        chk_reset_state("reset");
        chk("fwft reset r_valid", 32'(f.r_valid), 0);
        chk("fwft reset empty", 32'(f.empty), 1);

        // FWFT: data visible one cycle after the write edge, without r_en.
        f.w_en = 1; f.w_data = 8'h5A; cyc(); f.w_en = 0;
        chk("fwft head data", 32'(f.r_data), 32'h5A);
        chk("fwft head valid", 32'(f.r_valid), 1);
        f.r_en = 1; cyc(); f.r_en = 0;
        chk("fwft pop empty", 32'(f.empty), 1);
        chk("fwft pop valid", 32'(f.r_valid), 0);
        f.w_en = 1; f.w_data = 8'h01; cyc(); f.w_data = 8'h02; cyc(); f.w_en = 0;
        chk("fwft first of two", 32'(f.r_data), 32'h01);
        f.r_en = 1; cyc(); f.r_en = 0;
        chk("fwft next head", 32'(f.r_data), 32'h02);
        chk("fwft count", 32'(f.count), 1);

        // Fill 0x11..0x20 with flag boundaries.
        for (int i = 0; i < 16; i++) begin
            s.w_en = 1; s.w_data = 8'(32'h11 + i); cyc();
            if (i == 1) chk("ae at count 2", 32'(s.almost_empty), 1);
            if (i == 2) chk("ae at count 3", 32'(s.almost_empty), 0);
            if (i == 12) chk("af at count 13", 32'(s.almost_full), 0);
            if (i == 13) chk("af at count 14", 32'(s.almost_full), 1);
        end
        s.w_en = 0;
        chk("fill full", 32'(s.full), 1);
        chk("fill count", 32'(s.count), 16);
        chk("fill af", 32'(s.almost_full), 1);
        s.w_en = 1; s.w_data = 8'hAA; cyc(); s.w_en = 0;
        chk("17th write overflow", 32'(s.overflow), 1);
        chk("17th write count", 32'(s.count), 16);
        for (int i = 0; i < 16; i++) begin
            s.r_en = 1; cyc();
            chk("drain valid", 32'(s.r_valid), 1);
            chk("drain data", 32'(s.r_data), 32'h11 + i);
        end
        s.r_en = 0; cyc();
        chk("drained valid drops", 32'(s.r_valid), 0);
        chk("drained data holds", 32'(s.r_data), 32'h20);
        chk("drained empty", 32'(s.empty), 1);
        chk("drained underflow", 32'(s.underflow), 0);
        s.err_clr = 1; cyc(); s.err_clr = 0;
        chk("err_clr overflow", 32'(s.overflow), 0);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) begin s.w_en = 1; s.w_data = 8'(32'h40 + i); cyc(); end
        s.w_en = 0;
        for (int i = 0; i < 10; i++) begin
            s.r_en = 1; cyc(); chk("wrap a data", 32'(s.r_data), 32'h40 + i);
        end
        s.r_en = 0;
        for (int i = 0; i < 12; i++) begin s.w_en = 1; s.w_data = 8'(32'h60 + i); cyc(); end
        s.w_en = 0;
        chk("wrap count 12", 32'(s.count), 12);
        for (int i = 0; i < 12; i++) begin
            s.r_en = 1; cyc(); chk("wrap b data", 32'(s.r_data), 32'h60 + i);
        end
        s.r_en = 0; cyc();
        chk("wrap count 0", 32'(s.count), 0);
        chk("wrap overflow", 32'(s.overflow), 0);
        chk("wrap underflow", 32'(s.underflow), 0);

        // Simultaneous read and write when full.
        for (int i = 0; i < 16; i++) begin s.w_en = 1; s.w_data = 8'(32'h80 + i); cyc(); end
        s.r_en = 1; s.w_data = 8'hEE; cyc(); s.w_en = 0;
        chk("rw full overflow", 32'(s.overflow), 1);
        chk("rw full count", 32'(s.count), 15);
        chk("rw full data", 32'(s.r_data), 32'h80);
        for (int i = 1; i < 16; i++) begin
            cyc(); chk("rw full drain", 32'(s.r_data), 32'h80 + i);
        end
        s.r_en = 0; s.err_clr = 1; cyc(); s.err_clr = 0;
        chk("rw full emptied", 32'(s.count), 0);
        // Simultaneous read and write when empty.
        s.w_en = 1; s.r_en = 1; s.w_data = 8'h33; cyc(); s.w_en = 0; s.r_en = 0;
        chk("rw empty underflow", 32'(s.underflow), 1);
        chk("rw empty count", 32'(s.count), 1);
        chk("rw empty valid", 32'(s.r_valid), 0);
        s.err_clr = 1; cyc(); s.err_clr = 0;
        chk("err_clr underflow", 32'(s.underflow), 0);
        for (int i = 0; i < 4; i++) begin s.w_en = 1; s.w_data = 8'(32'h34 + i); cyc(); end
        s.w_data = 8'h38; s.r_en = 1; cyc(); s.w_en = 0; s.r_en = 0;
        chk("rw mid count", 32'(s.count), 5);
        chk("rw mid data", 32'(s.r_data), 32'h33);
        chk("rw mid ae", 32'(s.almost_empty), 0);
        // Threshold changes take effect the next cycle.
        s.ae_thresh = 5'd5; s.af_thresh = 5'd0; cyc();
        chk("live ae thresh", 32'(s.almost_empty), 1);
        chk("af thresh zero", 32'(s.almost_full), 1);
        s.ae_thresh = 5'd16; s.af_thresh = 5'd14; cyc();
        chk("af restored", 32'(s.almost_full), 0);
        chk("ae thresh depth", 32'(s.almost_empty), 1);
        s.ae_thresh = 5'd2;

        // err_clr vs. new overflow, then flush at count 7.
        for (int i = 0; i < 11; i++) begin s.w_en = 1; s.w_data = 8'(32'h39 + i); cyc(); end
        cyc();
        s.err_clr = 1; cyc(); s.w_en = 0; s.err_clr = 0;
        chk("set wins over clear", 32'(s.overflow), 1);
        s.r_en = 1; repeat (9) cyc(); s.r_en = 0;
        chk("pre-flush count", 32'(s.count), 7);
        s.flush = 1; s.w_en = 1; s.w_data = 8'hBB; s.r_en = 1; cyc();
        s.flush = 0; s.w_en = 0; s.r_en = 0;
        chk("flush count", 32'(s.count), 0);
        chk("flush empty", 32'(s.empty), 1);
        chk("flush r_valid", 32'(s.r_valid), 0);
        chk("flush keeps overflow", 32'(s.overflow), 1);
        chk("flush no underflow", 32'(s.underflow), 0);
        s.w_en = 1; s.w_data = 8'h21; cyc(); s.w_en = 0;
        chk("post-flush count", 32'(s.count), 1);
        s.r_en = 1; cyc(); s.r_en = 0;
        chk("post-flush data", 32'(s.r_data), 32'h21);

        // Reset during a read burst at count 9.
        for (int i = 0; i < 10; i++) begin s.w_en = 1; s.w_data = 8'(32'hC0 + i); cyc(); end
        s.w_en = 0; s.r_en = 1; cyc();
        chk("burst count", 32'(s.count), 9);
        rst = 1; cyc(); rst = 0; s.r_en = 0;
        chk_reset_state("mid-burst reset");
        s.w_en = 1; s.w_data = 8'h3C; cyc(); s.w_en = 0;
        s.r_en = 1; cyc(); s.r_en = 0;
        chk("after reset data", 32'(s.r_data), 32'h3C);
        chk("after reset valid", 32'(s.r_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
